// File: rtl/time_display_driver_pkg.sv
// Shared encodings and seven-segment codes for the time display back end.
package time_display_driver_pkg;

  localparam int unsigned KILO = 1000;

  typedef enum logic [1:0] {
    SELECT_NONE = 2'd0,
    SELECT_SEC  = 2'd1,
    SELECT_MIN  = 2'd2,
    SELECT_HOUR = 2'd3
  } select_e;

  localparam logic [6:0] SEG_DASH = 7'h40;

  function automatic logic [6:0] seg_digit(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'h3F;
      4'd1:    code = 7'h06;
      4'd2:    code = 7'h5B;
      4'd3:    code = 7'h4F;
      4'd4:    code = 7'h66;
      4'd5:    code = 7'h6D;
      4'd6:    code = 7'h7D;
      4'd7:    code = 7'h07;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h6F;
      default: code = SEG_DASH;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/time_display_driver_bcd_seg_encoder.sv
// Converts one binary time field into tens/ones segment codes; out-of-range values show dashes.
module time_display_driver_bcd_seg_encoder
  import time_display_driver_pkg::*;
(
  input  logic [5:0] value_i,
  input  logic       max23_i,
  output logic [6:0] tens_seg_o,
  output logic [6:0] ones_seg_o
);

  logic [3:0] tens_s;
  logic [3:0] ones_s;
  logic       over_s;

  // Split into decimal digits and flag values beyond the field's legal maximum.
  always_comb begin
    tens_s = 4'(value_i / 6'd10);
    ones_s = 4'(value_i % 6'd10);
    if (max23_i) begin
      over_s = (value_i > 6'd23);
    end else begin
      over_s = (value_i > 6'd59);
    end
    if (over_s) begin
      tens_seg_o = SEG_DASH;
      ones_seg_o = SEG_DASH;
    end else begin
      tens_seg_o = seg_digit(tens_s);
      ones_seg_o = seg_digit(ones_s);
    end
  end

endmodule

// File: rtl/time_display_driver.sv
// Six-digit multiplexed seven-segment driver for sec/min/hour with per-field and alert blinking.
module time_display_driver
  import time_display_driver_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ      = KILO,
  parameter int unsigned DIGIT_TICKS      = CLK_FREQ_HZ / KILO,
  parameter int unsigned BLINK_HALF_TICKS = CLK_FREQ_HZ / 2,
  parameter bit          SEG_ACTIVE_LOW   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [4:0] hour_in,
  input  logic [1:0] select,
  input  logic       alert_in,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int unsigned BW = (BLINK_HALF_TICKS > 1) ? $clog2(BLINK_HALF_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIGIT_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_TICKS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    slot_q, slot_d;
  logic          first_q;
  logic [5:0]    snap_sec_q, snap_sec_d, snap_min_q, snap_min_d;
  logic [4:0]    snap_hour_q, snap_hour_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d, cnt_eff_s;
  logic          blink_phase_q, blink_phase_d, phase_s;
  logic [1:0]    sel_prev_q;
  logic          alert_prev_q;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          wrap_s, restart_s, target_s, blank_s;
  logic [5:0]    view_sec_s, view_min_s;
  logic [4:0]    view_hour_s;
  logic [6:0]    sec_tens_s, sec_ones_s, min_tens_s, min_ones_s, hour_tens_s, hour_ones_s;
  logic [6:0]    digit_seg_s;

  // Slot prescaler; the first cycle after reset shows live inputs so slot 0 is never stale.
  always_comb begin
    presc_d = presc_q;
    slot_d  = slot_q;
    wrap_s  = 1'b0;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      if (slot_q == 3'd5) begin
        slot_d = 3'd0;
        wrap_s = 1'b1;
      end else begin
        slot_d = slot_q + 3'd1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
    if (first_q) begin
      view_sec_s  = sec_in;
      view_min_s  = min_in;
      view_hour_s = hour_in;
    end else begin
      view_sec_s  = snap_sec_q;
      view_min_s  = snap_min_q;
      view_hour_s = snap_hour_q;
    end
    if (first_q || wrap_s) begin
      snap_sec_d  = sec_in;
      snap_min_d  = min_in;
      snap_hour_d = hour_in;
    end else begin
      snap_sec_d  = snap_sec_q;
      snap_min_d  = snap_min_q;
      snap_hour_d = snap_hour_q;
    end
  end

  time_display_driver_bcd_seg_encoder u_sec_enc (
    .value_i(view_sec_s), .max23_i(1'b0), .tens_seg_o(sec_tens_s), .ones_seg_o(sec_ones_s)
  );
  time_display_driver_bcd_seg_encoder u_min_enc (
    .value_i(view_min_s), .max23_i(1'b0), .tens_seg_o(min_tens_s), .ones_seg_o(min_ones_s)
  );
  time_display_driver_bcd_seg_encoder u_hour_enc (
    .value_i({1'b0, view_hour_s}), .max23_i(1'b1), .tens_seg_o(hour_tens_s), .ones_seg_o(hour_ones_s)
  );

  // Blink timer; a restart counts as counter 0 in the same cycle so the field reappears at once.
  always_comb begin
    restart_s = (select != sel_prev_q) || (alert_in && !alert_prev_q);
    if (restart_s) begin
      cnt_eff_s = '0;
      phase_s   = 1'b0;
    end else begin
      cnt_eff_s = blink_cnt_q;
      phase_s   = blink_phase_q;
    end
    if (cnt_eff_s == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~phase_s;
    end else begin
      blink_cnt_d   = cnt_eff_s + BW'(1);
      blink_phase_d = phase_s;
    end
  end

  // Next display word for the current slot, with blanking and output polarity applied.
  always_comb begin
    case (slot_q)
      3'd0:    digit_seg_s = sec_ones_s;
      3'd1:    digit_seg_s = sec_tens_s;
      3'd2:    digit_seg_s = min_ones_s;
      3'd3:    digit_seg_s = min_tens_s;
      3'd4:    digit_seg_s = hour_ones_s;
      3'd5:    digit_seg_s = hour_tens_s;
      default: digit_seg_s = SEG_DASH;
    endcase
    if (alert_in) begin
      target_s = 1'b1;
    end else begin
      case (select)
        SELECT_SEC:  target_s = (slot_q[2:1] == 2'd0);
        SELECT_MIN:  target_s = (slot_q[2:1] == 2'd1);
        SELECT_HOUR: target_s = (slot_q[2:1] == 2'd2);
        default:     target_s = 1'b0;
      endcase
    end
    blank_s = phase_s && target_s;
    if (blank_s) begin
      an_d = {6{SEG_ACTIVE_LOW}};
      dp_d = SEG_ACTIVE_LOW;
    end else begin
      an_d = (6'b000001 << slot_q) ^ {6{SEG_ACTIVE_LOW}};
      dp_d = ((slot_q == 3'd2) || (slot_q == 3'd4)) ^ SEG_ACTIVE_LOW;
    end
    seg_d = digit_seg_s ^ {7{SEG_ACTIVE_LOW}};
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q       <= '0;
      slot_q        <= 3'd0;
      first_q       <= 1'b1;
      snap_sec_q    <= 6'd0;
      snap_min_q    <= 6'd0;
      snap_hour_q   <= 5'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sel_prev_q    <= SELECT_NONE;
      alert_prev_q  <= 1'b0;
      an_q          <= {6{SEG_ACTIVE_LOW}};
      seg_q         <= {7{SEG_ACTIVE_LOW}};
      dp_q          <= SEG_ACTIVE_LOW;
    end else begin
      presc_q       <= presc_d;
      slot_q        <= slot_d;
      first_q       <= 1'b0;
      snap_sec_q    <= snap_sec_d;
      snap_min_q    <= snap_min_d;
      snap_hour_q   <= snap_hour_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      sel_prev_q    <= select;
      alert_prev_q  <= alert_in;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
